// File: rtl/count_ones_accumulator_if.sv
// count_ones_accumulator_if
//   Stream bundle for the frame popcount accumulator.
//   Input side : in_valid / in_ready / in_data / in_last  (valid/ready beat stream)
//   Output side: out_valid / out_ready / out_count / out_beats / out_saturated
//   master modport: the producer of input beats and consumer of frame results.
//   slave modport : the accumulator itself.
interface count_ones_accumulator_if #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] out_count;
  logic [COUNT_WIDTH-1:0] out_beats;
  logic                   out_saturated;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_beats, out_saturated
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_beats, out_saturated
  );
endinterface

// File: rtl/count_ones_accumulator.sv
// count_ones_accumulator
//   Sums the set bits of every word in a valid/ready frame (frames end on
//   in_last) and presents one saturating total per frame.
//   Ports:
//     clock - rising-edge clock
//     reset - synchronous active-high reset; discards any partial frame and
//             any pending result
//     bus   - count_ones_accumulator_if.slave (input beat stream and frame
//             result stream, see the interface file)
//   Also holds count_ones, the combinational per-word population count.

// count_ones
//   data  - input word
//   count - number of set bits in data
module count_ones #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]   data,
  output logic [COUNT_W-1:0] count
);
  // Ripple sum of the individual bits.
  always_comb begin
    count = {COUNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      count = count + COUNT_W'(data[i]);
    end
  end
endmodule

module count_ones_accumulator #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  count_ones_accumulator_if.slave  bus
);
  localparam int WEIGHT_W = $clog2(WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_ACCUMULATE = 1'b0,
    ST_HOLD       = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_n_s;

  logic [WEIGHT_W-1:0]    weight_s;
  logic [COUNT_WIDTH:0]   weight_ext_s;
  logic [COUNT_WIDTH:0]   count_sum_s;
  logic [COUNT_WIDTH:0]   beats_sum_s;
  logic [COUNT_WIDTH-1:0] count_next_s;
  logic [COUNT_WIDTH-1:0] beats_next_s;
  logic                   sat_next_s;

  logic                   in_ready_s;
  logic                   accept_s;
  logic                   frame_end_s;

  logic [COUNT_WIDTH-1:0] acc_count_r;
  logic [COUNT_WIDTH-1:0] acc_beats_r;
  logic                   acc_sat_r;

  logic [COUNT_WIDTH-1:0] out_count_r;
  logic [COUNT_WIDTH-1:0] out_beats_r;
  logic                   out_sat_r;
  logic                   out_valid_r;

  count_ones #(
    .WIDTH   (WIDTH),
    .COUNT_W (WEIGHT_W)
  ) u_count_ones (
    .data  (bus.in_data),
    .count (weight_s)
  );

  // Saturating next values of the accumulators, including the current beat.
  // Sums are formed one bit wider so the carry-out flags saturation.
  always_comb begin
    weight_ext_s                 = {(COUNT_WIDTH + 1){1'b0}};
    weight_ext_s[WEIGHT_W-1:0]   = weight_s;
    count_sum_s                  = {1'b0, acc_count_r} + weight_ext_s;
    beats_sum_s                  = {1'b0, acc_beats_r} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    if (count_sum_s[COUNT_WIDTH]) begin
      count_next_s = COUNT_MAX;
    end else begin
      count_next_s = count_sum_s[COUNT_WIDTH-1:0];
    end
    if (beats_sum_s[COUNT_WIDTH]) begin
      beats_next_s = COUNT_MAX;
    end else begin
      beats_next_s = beats_sum_s[COUNT_WIDTH-1:0];
    end
    sat_next_s = acc_sat_r | count_sum_s[COUNT_WIDTH] | beats_sum_s[COUNT_WIDTH];
  end

  // Handshake: ready depends only on the held result and out_ready, never on in_valid.
  always_comb begin
    in_ready_s  = (~out_valid_r) | bus.out_ready;
    accept_s    = bus.in_valid & in_ready_s;
    frame_end_s = accept_s & bus.in_last;
  end

  // Next-state logic: a last beat always (re)enters HOLD; HOLD drains when the
  // consumer takes the result and no new frame ends in the same cycle.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_ACCUMULATE: begin
        if (frame_end_s) begin
          state_n_s = ST_HOLD;
        end else begin
          state_n_s = ST_ACCUMULATE;
        end
      end
      ST_HOLD: begin
        if (frame_end_s) begin
          state_n_s = ST_HOLD;
        end else if (bus.out_ready) begin
          state_n_s = ST_ACCUMULATE;
        end else begin
          state_n_s = ST_HOLD;
        end
      end
      default: begin
        state_n_s = ST_ACCUMULATE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_ACCUMULATE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Frame accumulators: add non-last beats, clear once the frame total is handed off.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_count_r <= {COUNT_WIDTH{1'b0}};
      acc_beats_r <= {COUNT_WIDTH{1'b0}};
      acc_sat_r   <= 1'b0;
    end else if (accept_s) begin
      if (bus.in_last) begin
        acc_count_r <= {COUNT_WIDTH{1'b0}};
        acc_beats_r <= {COUNT_WIDTH{1'b0}};
        acc_sat_r   <= 1'b0;
      end else begin
        acc_count_r <= count_next_s;
        acc_beats_r <= beats_next_s;
        acc_sat_r   <= sat_next_s;
      end
    end else begin
      acc_count_r <= acc_count_r;
      acc_beats_r <= acc_beats_r;
      acc_sat_r   <= acc_sat_r;
    end
  end

  // Result registers: capture the completed frame, valid mirrors the HOLD state.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_count_r <= {COUNT_WIDTH{1'b0}};
      out_beats_r <= {COUNT_WIDTH{1'b0}};
      out_sat_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_n_s == ST_HOLD);
      if (frame_end_s) begin
        out_count_r <= count_next_s;
        out_beats_r <= beats_next_s;
        out_sat_r   <= sat_next_s;
      end else begin
        out_count_r <= out_count_r;
        out_beats_r <= out_beats_r;
        out_sat_r   <= out_sat_r;
      end
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_count     = out_count_r;
  assign bus.out_beats     = out_beats_r;
  assign bus.out_saturated = out_sat_r;
endmodule

// File: doc/count_ones_accumulator.md
# count_ones_accumulator

Streaming population-count accumulator that sits directly downstream of `count_ones`. It accepts a valid/ready stream of `WIDTH`-bit words grouped into frames by `in_last`, sums the number of set bits across every word of a frame, and presents one frame total per frame on a valid/ready output. It is used for frame-level bit-density statistics and for parity/weight checks ahead of the encoding blocks.

## Interface
- `WIDTH`, 8, bits per input word; ≥ 1.
- `COUNT_WIDTH`, 16, width of the frame total and beat counter; ≥ `CLOG2(WIDTH+1)`.
- `clock` in 1, single clock, all logic on rising edge.
- `reset` in 1, synchronous active-high reset.
- `in_valid` in 1, input beat valid.
- `in_ready` out 1, input beat accepted when `in_valid && in_ready`.
- `in_data` in `WIDTH`, input word.
- `in_last` in 1, marks the final beat of a frame.
- `out_valid` out 1, frame result available.
- `out_ready` in 1, consumer takes the result when `out_valid && out_ready`.
- `out_count` out `COUNT_WIDTH`, total set bits in the frame, saturating.
- `out_beats` out `COUNT_WIDTH`, number of beats in the frame, saturating.
- `out_saturated` out 1, high if either `out_count` or `out_beats` saturated during the frame.

## Operation
- Per-beat weight: `popcount(in_data)`, `CLOG2(WIDTH+1)` bits wide, computed combinationally with a `count_ones` instance. The sum is zero-extended to `COUNT_WIDTH`.
- Internal state:
  - `acc_count` (`COUNT_WIDTH`)
  - `acc_beats` (`COUNT_WIDTH`)
  - `acc_sat` (1)
  - an output register set {`out_count`, `out_beats`, `out_saturated`, `out_valid`}.
- FSM has two states:
  - ACCUMULATE: `out_valid` = 0.
  - HOLD: `out_valid` = 1.
- `in_ready` = `!out_valid || out_ready`. This is combinational from `out_ready`. No combinational path exists from `in_valid` to `in_ready`.
- Accepted beat with `in_last` = 0:
  - `acc_count` ← sat(`acc_count` + weight).
  - `acc_beats` ← sat(`acc_beats` + 1).
  - `acc_sat` ← `acc_sat` OR either saturation event.
- Accepted beat with `in_last` = 1:
  - The output registers load the same saturated sums, including this beat.
  - `out_valid` ← 1 and the FSM moves to HOLD.
  - The accumulators clear to 0.
- Saturation: a result > 2^`COUNT_WIDTH`−1 clamps to 2^`COUNT_WIDTH`−1 and sets the sticky flag for the current frame only.
- In HOLD with `out_ready` = 0: all outputs are stable and `in_ready` = 0.
- In HOLD with `out_ready` = 1:
  - If a last beat is accepted in the same cycle, the output registers reload and `out_valid` stays 1. This is back-to-back operation with no bubble.
  - Otherwise `out_valid` ← 0 and the FSM returns to ACCUMULATE. Any non-last beat accepted that cycle still accumulates.
- Single-beat frames (`in_last` on the first beat) are legal and produce `out_beats` = 1.
- Reset mid-frame discards the partial frame and any pending result. No output is generated for it.

## Timing
- Reset values: `out_valid` = 0, `out_count` = 0, `out_beats` = 0, `out_saturated` = 0, accumulators = 0, FSM = ACCUMULATE. While `reset` is high, `in_ready` = 1 (follows `!out_valid`).
- Latency: a last beat accepted at edge N gives `out_valid` = 1 in the cycle after N, with the final result stable from that edge.
- Throughput: one beat per cycle, including frame boundaries, as long as `out_ready` stays high.
- While `in_valid` = 0 the accumulators hold their values.

## Test plan
- Reset, then the frame {8'hFF, 8'h0F, 8'h01 last} with `out_ready` = 1 → one cycle after the last beat: `out_count` = 13, `out_beats` = 3, `out_saturated` = 0, and `out_valid` is high for exactly 1 cycle.
- Single beat 8'h00 with `in_last` = 1 → `out_count` = 0, `out_beats` = 1.
- `out_ready` = 0 after the frame {8'hAA last} → `out_valid` holds with `out_count` = 4 and `in_ready` = 0. A beat presented meanwhile is not accepted. Raising `out_ready` pops the result and accepts that beat in the same cycle.
- Back-to-back frames {8'h01 last}, {8'h03 last}, {8'h07 last} with `out_ready` = 1 and `in_valid` high every cycle → `out_count` sequence 1, 2, 3 on consecutive cycles, `in_ready` never low.
- `COUNT_WIDTH` = 4, `WIDTH` = 8, frame of 3 beats of 8'hFF, last on the third → `out_count` = 15, `out_beats` = 3, `out_saturated` = 1. The next frame {8'h01 last} gives `out_saturated` = 0.
- Assert `reset` after 2 beats of a 4-beat frame, then send {8'h03 last} → `out_count` = 2, `out_beats` = 1. No output appears for the aborted frame.
